// File: rtl/seq_decoder.sv
// seq_decoder: maps codes 2,4,6,0,1,3,5,7 back to step indices 0..7,
// acquires lock on in-order runs, flags and counts out-of-order codes.
// Ports: clk, rst (async, active-low), in_valid, in_code[2:0], clr_err;
//        idx[2:0], idx_valid, locked, err, wrap, err_count[ERR_W-1:0].
module seq_decoder #(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       in_code,
  input  logic             clr_err,
  output logic [2:0]       idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    HUNT,
    ACQ,
    LOCKED
  } state_t;

  localparam logic [ERR_W-1:0] CNT_MAX = '1;
  localparam logic [2:0] LOCK_N = 3'(LOCK_CNT);
  localparam logic [2:0] UNLK_N = 3'(UNLOCK_CNT);

  state_t state, state_n;

  logic [2:0] exp_q, exp_n;
  logic [2:0] good_q, good_n;
  logic [2:0] miss_q, miss_n;
  logic [2:0] dec, idx_n;
  logic [2:0] good_inc, miss_inc;
  logic       match;
  logic       iv_n, err_n, wrap_n, lock_n;
  logic [ERR_W-1:0] cnt_n;

  always_comb begin
    dec = '0;
    unique case (in_code)
      3'd2: dec = 3'd0;
      3'd4: dec = 3'd1;
      3'd6: dec = 3'd2;
      3'd0: dec = 3'd3;
      3'd1: dec = 3'd4;
      3'd3: dec = 3'd5;
      3'd5: dec = 3'd6;
      3'd7: dec = 3'd7;
    endcase
  end

  assign match    = in_valid && (dec == exp_q);
  assign good_inc = good_q + 3'd1;
  assign miss_inc = miss_q + 3'd1;

  always_comb begin
    state_n = state;
    exp_n   = exp_q;
    good_n  = good_q;
    miss_n  = miss_q;
    idx_n   = idx;
    iv_n    = in_valid;
    err_n   = 1'b0;
    wrap_n  = 1'b0;
    if (in_valid) begin
      idx_n = dec;
      // resync: the next expected step follows whatever arrived
      exp_n = dec + 3'd1;
      unique case (1'b1)
        (state == HUNT): begin
          state_n = ACQ;
          good_n  = '0;
        end
        (state == ACQ): begin
          if (match) begin
            good_n = good_inc;
            if (good_inc == LOCK_N) begin
              state_n = LOCKED;
              miss_n  = '0;
            end
          end else begin
            good_n = '0;
          end
        end
        (state == LOCKED): begin
          if (match) begin
            miss_n = '0;
            wrap_n = (dec == 3'd0);
          end else begin
            err_n  = 1'b1;
            miss_n = miss_inc;
            if (miss_inc == UNLK_N) begin
              state_n = HUNT;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  assign lock_n = (state_n == LOCKED);

  // clear beats a coincident error; the err pulse itself still fires
  always_comb begin
    cnt_n = err_count;
    if (clr_err) begin
      cnt_n = '0;
    end else if (err_n && (err_count != CNT_MAX)) begin
      cnt_n = err_count + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HUNT;
      exp_q     <= '0;
      good_q    <= '0;
      miss_q    <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      wrap      <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      exp_q     <= exp_n;
      good_q    <= good_n;
      miss_q    <= miss_n;
      idx       <= idx_n;
      idx_valid <= iv_n;
      locked    <= lock_n;
      err       <= err_n;
      wrap      <= wrap_n;
      err_count <= cnt_n;
    end
  end

endmodule
